// File: rtl/main_memory_sync.sv
// Clocked block-wide backing store with req/ready/done handshake, programmable
// access latency and per-byte write enables.
module main_memory_sync #(
  parameter int unsigned MAIN_SIZE = 1024,
  parameter int unsigned BLOCK_W   = 128,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_req,
  input  logic                 in_row,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [BLOCK_W-1:0]   in_write_data,
  input  logic [BLOCK_W/8-1:0] in_byte_en,
  output logic                 out_ready,
  output logic                 out_done,
  output logic [BLOCK_W-1:0]   out_read_data
);

  localparam int unsigned BYTES    = BLOCK_W / 8;
  localparam int unsigned OFFSET_W = $clog2(BYTES);
  localparam int unsigned DEPTH    = MAIN_SIZE * 8 / BLOCK_W;
  localparam int unsigned IDX_W    = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef logic [BLOCK_W-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned n = 0; n < DEPTH; n++) m[n] = BLOCK_W'(n);
    return m;
  endfunction

  // Power-up image only; reset deliberately leaves the array untouched.
  mem_t mem_q = init_mem();

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               row_q, row_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]   be_q, be_d;
  logic               done_q, done_d;
  logic [BLOCK_W-1:0] rdata_q, rdata_d;
  logic               wr_en;
  logic               addr_offset_unused;

  assign addr_offset_unused = ^in_addr[OFFSET_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_req) begin
          row_d   = in_row;
          idx_d   = in_addr[ADDR_W-1:OFFSET_W];
          wdata_d = in_write_data;
          be_d    = in_byte_en;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (row_q) wr_en = 1'b1;
          else       rdata_d = mem_q[idx_q];
          done_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // An async reset drops state_q to IDLE at once, which kills wr_en before the edge.
  always_ff @(posedge in_clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign out_ready     = (state_q == IDLE);
  assign out_done      = done_q;
  assign out_read_data = rdata_q;

endmodule

// File: doc/main_memory_sync.md
Name: main_memory_sync

Overview:
- Clocked, parametrised successor to the combinational main memory. Serves one block-wide read or write per transaction.
- Uses a req/ready/done handshake, a programmable access latency and per-byte write enables.
- Sits below the cache controller as the backing store. It models realistic miss penalty and partial-block writeback.

Parameters:
- MAIN_SIZE, 1024, memory capacity in bytes; must equal 2**ADDR_W.
- BLOCK_W, 128, block width in bits; multiple of 8, power of two.
- ADDR_W, 10, byte address width.
- LATENCY, 4, cycles from accept to completion; legal range 1..255.

Derived values:
- OFFSET_W = log2(BLOCK_W/8).
- DEPTH = MAIN_SIZE*8/BLOCK_W.
- With the defaults: OFFSET_W = 4, DEPTH = 64.

Ports:
- in_clk  input  1  clock; all state changes on rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_req  input  1  transaction request.
- in_row  input  1  0 = read, 1 = write.
- in_addr  input  ADDR_W  byte address; block index = in_addr[ADDR_W-1:OFFSET_W].
- in_write_data  input  BLOCK_W  write block.
- in_byte_en  input  BLOCK_W/8  write byte enables; bit i covers bits [8i+7:8i].
- out_ready  output  1  block can accept a request this cycle.
- out_done  output  1  one-cycle completion pulse.
- out_read_data  output  BLOCK_W  result of most recent completed read.

Behaviour:
- Storage: DEPTH x BLOCK_W array. Power-up contents: block n = n, zero-extended. Reset never alters array contents.
- Reset (in_rst_n low, asynchronous) forces:
  - state IDLE, counter 0, out_done 0, out_read_data 0;
  - all captured request registers to 0.
  - Consequently out_ready = 1 once reset is released.
- FSM states are IDLE, BUSY and RESP. out_ready = (state == IDLE), decoded combinationally from state only.
- IDLE:
  - Request accepted at rising edge k when in_req = 1 and out_ready = 1.
  - On accept: capture in_row, block index, in_write_data and in_byte_en; load counter = LATENCY-1; go to BUSY.
  - in_req = 0 stays in IDLE.
- BUSY:
  - Inputs are ignored; captured values are used.
  - Counter != 0: decrement each edge.
  - Counter == 0 at an edge, perform the access:
    - read: out_read_data <= mem[idx];
    - write: for each i with byte_en[i] = 1, mem[idx] byte i <= write byte i; other bytes are unchanged.
  - In the same edge: out_done <= 1, state -> RESP.
- RESP: out_done is high for exactly this cycle. The next edge sets out_done <= 0 and returns to IDLE.
- Timing: accept at edge k, out_done high in the cycle after edge k+LATENCY, out_ready high again after edge k+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- out_read_data holds its value between reads; writes never modify it. Read data is valid while out_done is high and stays until the next read completes.
- Offset bits in_addr[OFFSET_W-1:0] are ignored (block-aligned access).
- in_byte_en is ignored for reads. A write with in_byte_en all zero completes normally and changes nothing.
- in_req while out_ready = 0 is dropped; it is not queued. The requester must hold in_req until it sees out_ready.
- Reset asserted in BUSY or RESP: the transaction is abandoned and an in-flight write does not update the array. No out_done is produced.
- Read of a block written earlier returns the updated value (write-then-read coherence).

Test Plan:
1. Default params, after reset: read in_addr = 0x050, req for one cycle at edge k -> out_done high only in the cycle after edge k+4; out_read_data = 128'd5; out_ready low from edge k to edge k+5.
2. Write in_addr = 0x3F0, data = {16{8'hA5}}, byte_en = 16'hFFFF; then read 0x3FC -> out_read_data = {16{8'hA5}} (block 63, offset ignored).
3. Partial write to block 2, data = {16{8'hFF}}, byte_en = 16'h000F; then read block 2 -> out_read_data = 128'h0000_..._FFFF_FFFF (upper 12 bytes 0, low 4 bytes FF).
4. Hold in_req high with a read of block 7 issued while BUSY on a read of block 1 -> first out_done returns 128'd1. The held request is accepted only in the next IDLE cycle, then returns 128'd7. Exactly two out_done pulses.
5. Start a write of 128'hDEAD to block 9, pull in_rst_n low in the second BUSY cycle -> outputs reset immediately, no out_done. A subsequent read of block 9 returns 128'd9.
6. LATENCY = 1 build: back-to-back reads of blocks 3 and 4 -> out_done pulses three cycles apart, data 128'd3 then 128'd4.
